cla_nibble_sequencer: RTL and testbench
=======================================

// Module: cla_nibble_sequencer
// PURPOSE
//  Multi-cycle WIDTH-bit add/sub unit that time-multiplexes one 4-bit carry_lookahead_adder
//  slice: feeds it one operand nibble per cycle (LSB first), consumes its s/cout, ripples the
//  carry through a register. Used in the EX stage for area-reduced ALU builds; the 4-bit adder
//  is instantiated outside and wired to the cla_* ports. valid/ready on both sides.
// PARAMETERS
//  WIDTH  32  operand/result width; multiple of 4 and >= 8, else elaboration $error
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands valid
//  in_ready   out  1      unit idle, accepts operands
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  sub        in   1      1: A-B (B inverted, carry-in 1); 0: A+B
//  out_valid  out  1      result valid, held until out_ready
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result
//  cout       out  1      carry out of MSB (sub: 1 = no borrow)
//  ovf        out  1      signed overflow
//  zero       out  1      sum == 0
//  cla_op1    out  4      to adder op1
//  cla_op2    out  4      to adder op2
//  cla_cin    out  1      to adder cin
//  cla_s      in   4      from adder s
//  cla_cout   in   1      from adder cout
// BEHAVIOUR
//  Clock is clk; reset is asynchronous, active-low on rst_n.
//  - N = WIDTH/4. States IDLE, BUSY, DONE; 2-bit state, idx counter clog2(N) bits.
//  - Reset (async, rst_n low): state=IDLE, idx=0, carry/sum/a/b regs=0; out_valid, sum,
//    cout, ovf, zero, cla_op1, cla_op2, cla_cin all 0. in_ready = rst_n & (state==IDLE), so 0 in reset.
//  - IDLE: in_ready=1. in_valid&in_ready at edge: a_r<=a, b_r<=sub?~b:b, carry<=sub,
//    idx<=0, ->BUSY. No accept in BUSY/DONE (in_ready=0).
//  - BUSY: combinational cla_op1=a_r[4*idx+:4], cla_op2=b_r[4*idx+:4], cla_cin=carry.
//    Each edge: sum_r[4*idx+:4]<=cla_s, carry<=cla_cout, idx<=idx+1. On idx==N-1: ->DONE,
//    cout<=cla_cout, ovf<=cin_msb^cla_cout, where cin_msb=a_r[W-1]^b_r[W-1]^cla_s[3].
//  - Outside BUSY cla_op1/cla_op2/cla_cin drive 0.
//  - DONE: out_valid=1; sum/cout/ovf/zero stable. out_valid&out_ready at edge ->IDLE,
//    out_valid drops next cycle; sum/cout/ovf retain last value until next DONE.
//  - Latency: out_valid high exactly N cycles after the accepting edge (8 for WIDTH=32).
//    Min accept-to-accept spacing N+2 cycles (out_ready held 1).
//  - zero = (sum_r == 0), valid only when out_valid.
//  - in_valid/operand changes during BUSY/DONE ignored; latched copies used.
//  - out_ready low in DONE: stall indefinitely, no output change.
//  - Reset mid-BUSY/DONE: operation discarded, out_valid 0 immediately; after release
//    in_ready 1 on first cycle, no stale result emitted.
//  - idx never exceeds N-1; no wrap in BUSY.
// TESTING (WIDTH=32, behavioural carry_lookahead_adder on cla_* ports)
//  1. a=0x0000_0001,b=0xFFFF_FFFF,sub=0 -> sum=0,cout=1,ovf=0,zero=1; out_valid 8 cycles after accept.
//  2. a=0x7FFF_FFFF,b=1,sub=0 -> sum=0x8000_0000,cout=0,ovf=1,zero=0.
//  3. a=5,b=7,sub=1 -> sum=0xFFFF_FFFE,cout=0,ovf=0; a=0x8000_0000,b=1,sub=1 -> 0x7FFF_FFFF,cout=1,ovf=1.
//  4. out_ready=0 for 5 cycles in DONE, in_valid=1 with new ops -> outputs stable, in_ready=0,
//     new op accepted only after handshake+IDLE; both results correct.
//  5. rst_n low during BUSY idx=3 -> out_valid=0, cla_* = 0 at once; after release next op correct.
//  6. a=0x8765_4321,b=0x1111_1111: in BUSY cycle k, cla_op1=nibble k of a, cla_op2=0x1,
//     cla_cin=prior cla_cout; sum=0x9876_5432.

Source files
------------

// File: rtl/cla_nibble_sequencer.sv
// cla_nibble_sequencer
//   Multi-cycle WIDTH-bit add/subtract unit built around one external 4-bit
//   carry-lookahead adder slice. The operands are latched when the unit
//   accepts them. One nibble per cycle is then presented to the slice, LSB
//   nibble first. The slice's sum nibble is stored and its carry is rippled
//   through a register into the next cycle. The result is held with
//   valid/ready until the consumer takes it.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   operand handshake; in_ready only while idle
//   a, b, sub             operands; sub=1 computes a-b (b inverted, cin=1)
//   out_valid / out_ready result handshake; result held until taken
//   sum, cout, ovf, zero  result, MSB carry (sub: 1 = no borrow),
//                         signed overflow, sum==0 (qualified by out_valid)
//   cla_op1/op2/cla_cin   nibble operands and carry to the external slice
//   cla_s/cla_cout        sum nibble and carry back from the slice
module cla_nibble_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [3:0]       cla_op1,
  output logic [3:0]       cla_op2,
  output logic             cla_cin,
  input  logic [3:0]       cla_s,
  input  logic             cla_cout
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
    $error("cla_nibble_sequencer: WIDTH must be a multiple of 4 and >= 8");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Operands and result are stored as nibble arrays so that the
  // per-cycle slice is a plain index by idx.
  logic [N-1:0][3:0] a_r, b_r, sum_r;
  logic [IW-1:0]     idx;
  logic              carry;
  logic              cout_r, ovf_r;

  logic accept, retire, last_nib, cin_msb;

  assign in_ready  = rst_n & (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign retire    = out_valid & out_ready;
  assign last_nib  = (idx == IW'(N - 1));

  // Carry into the MSB is recovered from the top sum bit and the MSB
  // operands. This avoids exposing the slice's internal bit-3 carry.
  // Overflow is that carry XOR the carry out of the MSB.
  assign cin_msb = a_r[N-1][3] ^ b_r[N-1][3] ^ cla_s[3];

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = BUSY;
      BUSY:    if (last_nib) state_nxt = DONE;
      DONE:    if (retire)   state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      sum_r  <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= sub;
            idx   <= '0;
          end
        end
        BUSY: begin
          sum_r[idx] <= cla_s;
          carry      <= cla_cout;
          if (last_nib) begin
            // Park idx at 0 rather than running past N-1.
            idx    <= '0;
            cout_r <= cla_cout;
            ovf_r  <= cin_msb ^ cla_cout;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // The slice sees zeros whenever the unit is not busy.
  always_comb begin
    cla_op1 = '0;
    cla_op2 = '0;
    cla_cin = 1'b0;
    if (state == BUSY) begin
      cla_op1 = a_r[idx];
      cla_op2 = b_r[idx];
      cla_cin = carry;
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;
  // Gating with out_valid keeps zero low in reset and between results.
  assign zero = out_valid & ~|sum_r;

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
module tb_cla_nibble_sequencer;
  localparam int W = 32;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, sub, out_valid, out_ready;
  logic [W-1:0] a, b, sum;
  logic         cout, ovf, zero;
  logic [3:0]   cla_op1, cla_op2, cla_s;
  logic         cla_cin, cla_cout;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Behavioural 4-bit adder slice
  assign {cla_cout, cla_s} = 5'(cla_op1) + 5'(cla_op2) + 5'(cla_cin);

  cla_nibble_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero),
    .cla_op1(cla_op1), .cla_op2(cla_op2), .cla_cin(cla_cin),
    .cla_s(cla_s), .cla_cout(cla_cout)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: unsigned arithmetic for sum and carry, and signed
  // 64-bit arithmetic for the overflow range test.
  task automatic model(input logic [31:0] ai, input logic [31:0] bi, input logic si,
                       output logic [31:0] s, output logic c, output logic o, output logic z);
    longint sa, sb, r;
    sa = longint'($signed(ai));
    sb = longint'($signed(bi));
    if (si) begin
      s = ai - bi;
      c = (ai >= bi);
      r = sa - sb;
    end else begin
      s = ai + bi;
      c = ({1'b0, ai} + {1'b0, bi}) > 33'hFFFF_FFFF;
      r = sa + sb;
    end
    o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    z = (s == 32'h0);
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Entered and left at 1 ns after a rising edge.
  task automatic do_op(input string nm, input logic [31:0] ai, input logic [31:0] bi,
                       input logic si, input logic [31:0] es, input logic ec,
                       input logic eo, input logic ez);
    int cyc, w;
    w = 0;
    while (!in_ready && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    chk({nm, " in_ready"}, in_ready, 1);
    a = ai; b = bi; sub = si; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    // These changes to the operands must be ignored.
    in_valid = 1'b0; a = $urandom; b = $urandom; sub = 1'($urandom);
    wait_out(cyc);
    chk({nm, " latency"}, cyc, N);
    chk({nm, " sum"},  sum,  es);
    chk({nm, " cout"}, cout, ec);
    chk({nm, " ovf"},  ovf,  eo);
    chk({nm, " zero"}, zero, ez);
    @(posedge clk); #1;
    chk({nm, " out_valid drop"}, out_valid, 0);
  endtask

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] es, ex_s, ey_s;
    logic        ec, eo, ez, ex_c, ex_o, ex_z, ey_c, ey_o, ey_z;
    logic [63:0] av, bv, mask;
    logic        prev_cout;
    int          cyc;
    bit          stale;

    vecs[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{32'h8765_4321, 32'h1111_1111, 1'b0, 32'h9876_5432, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready",  in_ready,  0);
    chk("rst out_valid", out_valid, 0);
    chk("rst sum",  sum,  0);
    chk("rst cout", cout, 0);
    chk("rst ovf",  ovf,  0);
    chk("rst zero", zero, 0);
    chk("rst cla",  {cla_op1, cla_op2, cla_cin}, 0);
    rst_n = 1'b1;
    #1;
    chk("post-rst in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 8; i++)
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
            vecs[i].sum, vecs[i].cout, vecs[i].ovf, vecs[i].zero);

    // Per-nibble slice traffic for 0x87654321 + 0x11111111
    av = 64'h8765_4321; bv = 64'h1111_1111;
    a = av[31:0]; b = bv[31:0]; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    prev_cout = 1'b0;
    for (int k = 0; k < N; k++) begin
      mask = (64'h1 << (4 * k)) - 64'h1;
      chk($sformatf("nib%0d op1", k), cla_op1, (av >> (4 * k)) & 64'hF);
      chk($sformatf("nib%0d op2", k), cla_op2, 4'h1);
      chk($sformatf("nib%0d cin", k), cla_cin, (((av & mask) + (bv & mask)) >> (4 * k)) & 64'h1);
      if (k > 0) chk($sformatf("nib%0d cin=prev cout", k), cla_cin, prev_cout);
      prev_cout = cla_cout;
      @(posedge clk); #1;
    end
    chk("nib out_valid", out_valid, 1);
    chk("nib sum", sum, 32'h9876_5432);
    chk("nib cla idle", {cla_op1, cla_op2, cla_cin}, 0);
    @(posedge clk); #1;

    // Stall in DONE with new operands waiting
    model(32'h1234_5678, 32'h0F0F_0F0F, 1'b0, ex_s, ex_c, ex_o, ex_z);
    model(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, ey_s, ey_c, ey_o, ey_z);
    a = 32'h1234_5678; b = 32'h0F0F_0F0F; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    a = 32'hFFFF_FFFF; b = 32'h0000_0001; sub = 1'b1;
    wait_out(cyc);
    chk("stall latency", cyc, N);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall%0d out_valid", i), out_valid, 1);
      chk($sformatf("stall%0d in_ready", i), in_ready, 0);
      chk($sformatf("stall%0d sum", i), sum, ex_s);
      chk($sformatf("stall%0d cout/ovf", i), {cout, ovf}, {ex_c, ex_o});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall released out_valid", out_valid, 0);
    chk("stall released in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("second accepted", in_ready, 0);
    wait_out(cyc);
    chk("second latency", cyc, N);
    chk("second sum", sum, ey_s);
    chk("second cout/ovf/zero", {cout, ovf, zero}, {ey_c, ey_o, ey_z});
    @(posedge clk); #1;

    // Reset while busy at idx=3
    a = 32'hAAAA_AAAA; b = 32'h3333_3333; sub = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre-rst op1 nib3", cla_op1, 4'hA);
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst in_ready", in_ready, 0);
    chk("midrst cla", {cla_op1, cla_op2, cla_cin}, 0);
    chk("midrst sum", sum, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    #1;
    chk("rst release in_ready", in_ready, 1);
    stale = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    chk("no stale result", stale, 0);
    model(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, es, ec, eo, ez);
    do_op("after rst", 32'hDEAD_BEEF, 32'h0123_4567, 1'b1, es, ec, eo, ez);

    // Random operations against the model
    for (int i = 0; i < 30; i++) begin
      logic [31:0] ra, rb;
      logic        rs;
      ra = $urandom; rb = $urandom; rs = 1'($urandom);
      if (i % 7 == 0) rb = rs ? ra : (~ra + 32'h1);
      model(ra, rb, rs, es, ec, eo, ez);
      do_op($sformatf("rand%0d", i), ra, rb, rs, es, ec, eo, ez);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
